// File: rtl/s2p_converter.sv
`default_nettype none
// ============================================================================
// Module      : s2p_converter
// Description : Serial-to-parallel converter. Collects N serial bits over a
//               valid/ready handshake into a word and presents completed
//               words on a parallel valid/ready interface. A one-word output
//               register plus the in-progress shift register sustain full
//               serial throughput while the consumer keeps up.
// Revision    : 1.0 - initial release
// ============================================================================
module s2p_converter #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    input  logic         s_data,
    output logic         s_ready,
    output logic         p_valid,
    output logic [N-1:0] p_data,
    input  logic         p_ready
);

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

    // Serial-side state: FILL accepts bits, STALL holds a completed word
    // in the shift register until the output register frees up.
    localparam logic [0:0]     FILL     = 1'b0;
    localparam logic [0:0]     STALL    = 1'b1;

    logic [0:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [N-1:0]  shift_q,     shift_d;
    logic [N-1:0]  out_reg_q,   out_reg_d;
    logic          out_valid_q, out_valid_d;

    logic          beat;
    logic          xfer;
    logic [N-1:0]  shift_next;

    // Shift direction chooses where the first received bit ends up.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_q[N-2:0], s_data};
        end else begin : g_lsb_first
            assign shift_next = {s_data, shift_q[N-1:1]};
        end
    endgenerate

    assign beat = s_valid && (state_q == FILL);
    assign xfer = out_valid_q && p_ready;

    // Next-state logic for assembly, stall handling and output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        out_reg_d   = out_reg_q;
        out_valid_d = out_valid_q;

        // A departing word empties the output unless replaced below.
        if (xfer) begin
            out_valid_d = 1'b0;
        end

        if (beat) begin
            shift_d = shift_next;
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (!out_valid_q || p_ready) begin
                    // Output register is free (or freeing now): load directly.
                    out_reg_d   = shift_next;
                    out_valid_d = 1'b1;
                end else begin
                    // Keep the finished word in the shift register.
                    state_d = STALL;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if ((state_q == STALL) && xfer) begin
            // Pending word moves up as the held word leaves: no bubble.
            out_reg_d   = shift_q;
            out_valid_d = 1'b1;
            state_d     = FILL;
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_reg_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_reg_q   <= out_reg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s_ready = (state_q == FILL);
    assign p_valid = out_valid_q;
    assign p_data  = out_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_s2p_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_s2p_converter
// Description : Self-checking bench for s2p_converter: table-driven vectors,
//               hand-written corner sequences and a randomized run against a
//               word-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s2p_converter;

    logic       clk;
    logic       rstn;
    logic       s_valid;
    logic       s_data;
    logic       p_ready;

    logic       sr4, pv4;
    logic [3:0] pd4;
    logic       srm, pvm;
    logic [3:0] pdm;
    logic       sr8, pv8;
    logic [7:0] pd8;

    int tests_run = 0;
    int tests_failed = 0;

    s2p_converter #(.N(4), .MSB_FIRST(1'b0)) u_dut4 (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .s_ready(sr4), .p_valid(pv4), .p_data(pd4), .p_ready(p_ready));

    s2p_converter #(.N(4), .MSB_FIRST(1'b1)) u_dutm (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .s_ready(srm), .p_valid(pvm), .p_data(pdm), .p_ready(p_ready));

    s2p_converter #(.N(8), .MSB_FIRST(1'b0)) u_dut8 (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .s_ready(sr8), .p_valid(pv8), .p_data(pd8), .p_ready(p_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (actual running, required finished)");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       sv;
        logic       sd;
        logic       pr;
        logic       sr;
        logic       pv;
        logic [3:0] pd;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic sv, input logic sd, input logic pr);
        s_valid = sv;
        s_data  = sd;
        p_ready = pr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = 1'b0;
        p_ready = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Reference model state: completed words awaiting hand-off and the
    // bits of the word being collected.
    logic [3:0] mq[$];
    logic       mbits[$];
    logic [3:0] mlast;

    initial begin
        logic [3:0] w;
        logic       sv, sd, pr;
        logic       exp_sr, exp_pv;
        logic [3:0] exp_pd;
        logic [7:0] byte_v;

        // Test 1..3 vectors: inputs for a cycle, outputs after its edge.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hD};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hD};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hD};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hD};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hD};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hC};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hC};
        vecs[25] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hC};

        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = 1'b0;
        p_ready = 1'b0;
        do_reset();
        chk("reset s_ready", 32'(sr4), 32'd1);
        chk("reset p_valid", 32'(pv4), 32'd0);
        chk("reset p_data",  32'(pd4), 32'd0);

        // Table-driven: single word, streaming words, backpressure.
        for (int i = 0; i < 26; i++) begin
            step(vecs[i].sv, vecs[i].sd, vecs[i].pr);
            chk($sformatf("vec%0d s_ready", i), 32'(sr4), 32'(vecs[i].sr));
            chk($sformatf("vec%0d p_valid", i), 32'(pv4), 32'(vecs[i].pv));
            chk($sformatf("vec%0d p_data",  i), 32'(pd4), 32'(vecs[i].pd));
        end

        // Sparse input: bits 0,1,1,0 with two idle cycles between them.
        do_reset();
        begin
            logic [3:0] bits_v;
            bits_v = 4'b0110;
            for (int b = 0; b < 4; b++) begin
                step(1'b1, bits_v[b], 1'b1);
                chk($sformatf("sparse beat%0d p_valid", b), 32'(pv4), (b == 3) ? 32'd1 : 32'd0);
                if (b < 3) begin
                    step(1'b0, 1'b1, 1'b1);
                    step(1'b0, 1'b1, 1'b1);
                    chk($sformatf("sparse gap%0d p_valid", b), 32'(pv4), 32'd0);
                end
            end
            chk("sparse p_data", 32'(pd4), 32'h6);
        end

        // Reset mid-word discards the partial word.
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        do_reset();
        chk("midreset s_ready", 32'(sr4), 32'd1);
        chk("midreset p_valid", 32'(pv4), 32'd0);
        chk("midreset p_data",  32'(pd4), 32'd0);
        for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 1'b1);
        chk("after reset p_valid", 32'(pv4), 32'd1);
        chk("after reset p_data",  32'(pd4), 32'hF);

        // MSB-first: bits 1,0,0,0 produce 4'h8.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("msb pre p_valid", 32'(pvm), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("msb p_valid", 32'(pvm), 32'd1);
        chk("msb p_data",  32'(pdm), 32'h8);

        // N=8 LSB-first: byte 8'hA5.
        do_reset();
        byte_v = 8'hA5;
        for (int b = 0; b < 8; b++) begin
            step(1'b1, byte_v[b], 1'b1);
            if (b == 6) chk("n8 pre p_valid", 32'(pv8), 32'd0);
        end
        chk("n8 p_valid", 32'(pv8), 32'd1);
        chk("n8 p_data",  32'(pd8), 32'hA5);
        chk("n8 s_ready", 32'(sr8), 32'd1);

        // Randomized run against the word-queue model.
        do_reset();
        mq.delete();
        mbits.delete();
        mlast = 4'h0;
        for (int c = 0; c < 600; c++) begin
            sv = ($urandom_range(0, 3) != 0);
            sd = 1'($urandom_range(0, 1));
            pr = ($urandom_range(0, 2) == 0) ? 1'b1 : ((c % 64) < 32);
            // Model update using the state before this edge.
            begin
                logic do_beat, do_xfer;
                do_beat = sv && (mq.size() < 2);
                do_xfer = (mq.size() > 0) && pr;
                if (do_xfer) mlast = mq.pop_front();
                if (do_beat) begin
                    mbits.push_back(sd);
                    if (mbits.size() == 4) begin
                        w = '0;
                        for (int i = 0; i < 4; i++) w[i] = mbits[i];
                        mq.push_back(w);
                        mbits.delete();
                    end
                end
            end
            step(sv, sd, pr);
            exp_sr = (mq.size() < 2);
            exp_pv = (mq.size() > 0);
            exp_pd = exp_pv ? mq[0] : mlast;
            chk($sformatf("rand%0d s_ready", c), 32'(sr4), 32'(exp_sr));
            chk($sformatf("rand%0d p_valid", c), 32'(pv4), 32'(exp_pv));
            chk($sformatf("rand%0d p_data",  c), 32'(pd4), 32'(exp_pd));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s2p_converter.md
Name: s2p_converter

Overview:
Serial-to-parallel converter and receive-side counterpart of the team's parallel-to-serial converter. It accepts one bit per serial valid/ready handshake and assembles N bits into a word, LSB-first by default. Each completed word is presented on a parallel valid/ready interface. A one-word output holding register plus an in-progress shift register give full serial throughput (N bits per N cycles) while the parallel consumer is not stalling.

Parameters:
N, 4, word width in bits; legal range N >= 2.
MSB_FIRST, 0, bit order. 0 = first serial bit lands in p_data[0], matching the converter's LSB-first transmit order. 1 = first serial bit lands in p_data[N-1].

Ports:
clk  input  1  clock; all state updates on rising edge.
rstn  input  1  reset, synchronous and active-low.
s_valid  input  1  serial bit valid.
s_data  input  1  serial bit; ignored when s_valid=0.
s_ready  output  1  converter can accept a serial bit.
p_valid  output  1  assembled word available on p_data.
p_data  output  N  assembled word.
p_ready  input  1  downstream accepts word.

Behaviour:
- Handshakes:
  - Serial beat = s_valid && s_ready at a rising edge.
  - Parallel transfer = p_valid && p_ready at a rising edge.
- Reset: rstn sampled low at a rising edge clears all state:
  - cnt=0, shift register=0, pending=0, out_reg=0, out_valid=0.
  - Outputs after that edge: s_ready=1, p_valid=0, p_data=0.
  - A partial word in progress and any held or pending words are discarded.
- Internal state:
  - cnt: $clog2(N) bits, counts accepted beats within the current word.
  - Shift register: N bits.
  - pending flag: serial-side states FILL (pending=0) and STALL (pending=1).
  - out_reg and out_valid: parallel-side states EMPTY and FULL.
- Outputs:
  - s_ready = !pending, driven from a register only; no combinational path from p_ready.
  - p_valid = out_valid.
  - p_data = out_reg.
- Bit placement:
  - MSB_FIRST=0: each beat shifts right, new bit entering at [N-1]. After N beats the first bit sits at [0].
  - MSB_FIRST=1: each beat shifts left, new bit entering at [0].
- FILL, beat with cnt < N-1: shift, cnt+1.
- FILL, beat with cnt == N-1 (word completes):
  - The assembled word includes the current s_data.
  - If out_valid=0 or p_ready=1 that cycle: out_reg <= word, out_valid <= 1, cnt <= 0; remain in FILL.
  - Otherwise: word is held in the shift register, pending <= 1 (go to STALL), cnt <= 0.
- STALL: no serial beats (s_ready=0). On a parallel transfer, out_reg <= shift-register word, out_valid stays 1, pending <= 0 (back to FILL).
- Parallel side: a transfer with no new word arriving the same edge clears out_valid (FULL -> EMPTY).
- Simultaneous transfer and word completion at the same edge: the new word replaces the outgoing word and p_valid stays 1. No bubble, no loss.
- Latency: the Nth beat at edge k gives p_valid=1 and the new p_data in the cycle after edge k.
- p_data is stable while p_valid=1 and p_ready=0.
- Idle cycles (s_valid=0) do not advance cnt. Gaps between bits are allowed anywhere in a word.
- No word is ever dropped or overwritten. At most 2 complete words are buffered: 1 in out_reg and 1 pending.

Test Plan:
1. N=4, MSB_FIRST=0, p_ready=1: serial bits 1,0,1,1 back-to-back -> p_valid=1 for exactly one cycle after the 4th beat, p_data=4'hD, s_ready=1 throughout.
2. Continuous s_valid, p_ready=1: words 4'hA then 4'h5 (bits 0,1,0,1,1,0,1,0) -> s_ready never drops; p_valid pulses 4 cycles apart with 4'hA then 4'h5.
3. Backpressure:
   - Stimulus: p_ready=0; send 4'h3 then 4'hC.
   - After the 8th beat: s_ready=0, p_data holds 4'h3.
   - Raise p_ready for one cycle: 4'h3 transfers; next cycle p_data=4'hC, p_valid=1, s_ready=1.
   - Then 4'hC transfers when p_ready is raised again.
4. Sparse input: bits 0,1,1,0 with 2 idle s_valid=0 cycles between each -> single word 4'h6; p_valid only after the 4th beat.
5. Reset mid-word: 2 beats accepted, rstn=0 for one edge, then bits 1,1,1,1 -> p_data=4'hF (partial discarded), p_valid=0 and s_ready=1 immediately after the reset edge.
6. MSB_FIRST=1, N=4: bits 1,0,0,0 -> p_data=4'h8. Also N=8 with MSB_FIRST=0: byte 8'hA5 sent LSB-first -> p_data=8'hA5.
